mcycle_unit: RTL

Iterative multiply/divide unit for the multi-cycle processor core; it generates the `Busy` stall that the program counter and pipeline registers consume. One 32×32 operation is accepted per `Start` pulse. Results are computed one bit per cycle. `Busy` stays high until the results are valid in a one-cycle completion slot, where the stalled instruction writes back.

---
 rtl/mcycle_pkg.sv | 24 ++
 rtl/mcycle_if.sv | 15 +
 rtl/mcycle_sign_adj.sv | 10 +
 rtl/mcycle_unit.sv | 135 +++++++++++++
 4 files changed

// File: rtl/mcycle_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package mcycle_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPUTING = 2'd1,
    DONE      = 2'd2
  } state_t;

  // MCycleOp bit positions and encodings
  localparam int   OP_FUNC_BIT = 1;
  localparam int   OP_SIGN_BIT = 0;
  localparam logic OP_MUL      = 1'b0;
  localparam logic OP_DIV      = 1'b1;
  localparam logic OP_SIGNED   = 1'b1;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = $clog2(WIDTH_DEF);

  function automatic int cnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/mcycle_if.sv
// Request/result bundle between decode and the multiply/divide unit.
interface mcycle_if #(parameter int WIDTH = 32);
  logic             Start;
  logic [1:0]       MCycleOp;
  logic [WIDTH-1:0] Operand1;
  logic [WIDTH-1:0] Operand2;
  logic [WIDTH-1:0] Result1;
  logic [WIDTH-1:0] Result2;
  logic             Busy;

  modport master (output Start, MCycleOp, Operand1, Operand2,
                  input  Result1, Result2, Busy);
  modport slave  (input  Start, MCycleOp, Operand1, Operand2,
                  output Result1, Result2, Busy);
endinterface

// File: rtl/mcycle_sign_adj.sv
// Conditional two's-complement negate; only built when MCYCLE_SIGNED_EN is defined.
`ifdef MCYCLE_SIGNED_EN
module mcycle_sign_adj #(parameter int WIDTH = 32) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] result
);
  assign result = negate ? ((~value) + WIDTH'(1)) : value;
endmodule
`endif

// File: rtl/mcycle_unit.sv
// Iterative shift-add multiply / restoring divide, one bit per cycle, with Busy stall.
// Signed operation is compiled in only when MCYCLE_SIGNED_EN is defined.
module mcycle_unit
  import mcycle_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     CLK,
  input  logic     Reset,
  mcycle_if.slave  bus
);

  localparam int            CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t             state;
  logic [CW-1:0]      count;
  logic               is_div;
  logic               div_zero;
  logic [WIDTH-1:0]   op1_raw;
  logic [WIDTH-1:0]   addend;   // multiplicand for multiply, divisor for divide
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   res1, res2;

  logic [WIDTH-1:0]   mag1, mag2;
  logic [2*WIDTH-1:0] prod_fin;
  logic [WIDTH-1:0]   quot_fin, rem_fin;

  logic [WIDTH:0]     add_sum, rem_sh, sub_diff;

  // One iteration: add-then-shift for multiply, shift-then-trial-subtract for divide
  always_comb begin
    add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, addend} : '0);
    rem_sh   = acc[2*WIDTH-1:WIDTH-1];
    sub_diff = rem_sh - {1'b0, addend};
    acc_nxt  = {add_sum, acc[WIDTH-1:1]};
    if (is_div) begin
      if (sub_diff[WIDTH])
        acc_nxt = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else
        acc_nxt = {sub_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
  end

`ifdef MCYCLE_SIGNED_EN
  logic sgn_op, s1, s2;
  logic neg_res, neg_rem;

  assign sgn_op = (bus.MCycleOp[OP_SIGN_BIT] == OP_SIGNED);
  assign s1     = sgn_op & bus.Operand1[WIDTH-1];
  assign s2     = sgn_op & bus.Operand2[WIDTH-1];

  mcycle_sign_adj #(.WIDTH(WIDTH))   u_mag1 (.value(bus.Operand1), .negate(s1), .result(mag1));
  mcycle_sign_adj #(.WIDTH(WIDTH))   u_mag2 (.value(bus.Operand2), .negate(s2), .result(mag2));
  mcycle_sign_adj #(.WIDTH(2*WIDTH)) u_prod (.value(acc_nxt), .negate(neg_res), .result(prod_fin));
  mcycle_sign_adj #(.WIDTH(WIDTH))   u_quot (.value(acc_nxt[WIDTH-1:0]), .negate(neg_res),
                                             .result(quot_fin));
  mcycle_sign_adj #(.WIDTH(WIDTH))   u_rem  (.value(acc_nxt[2*WIDTH-1:WIDTH]), .negate(neg_rem),
                                             .result(rem_fin));
`else
  logic unused_sign_bit;
  assign unused_sign_bit = bus.MCycleOp[OP_SIGN_BIT];
  assign mag1     = bus.Operand1;
  assign mag2     = bus.Operand2;
  assign prod_fin = acc_nxt;
  assign quot_fin = acc_nxt[WIDTH-1:0];
  assign rem_fin  = acc_nxt[2*WIDTH-1:WIDTH];
`endif

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state    <= IDLE;
      count    <= '0;
      is_div   <= 1'b0;
      div_zero <= 1'b0;
      op1_raw  <= '0;
      addend   <= '0;
      acc      <= '0;
      res1     <= '0;
      res2     <= '0;
`ifdef MCYCLE_SIGNED_EN
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.Start) begin
            is_div   <= (bus.MCycleOp[OP_FUNC_BIT] == OP_DIV);
            div_zero <= (bus.Operand2 == '0);
            op1_raw  <= bus.Operand1;
            count    <= '0;
            if (bus.MCycleOp[OP_FUNC_BIT] == OP_DIV) begin
              addend <= mag2;
              acc    <= {{WIDTH{1'b0}}, mag1};
            end else begin
              addend <= mag1;
              acc    <= {{WIDTH{1'b0}}, mag2};
            end
`ifdef MCYCLE_SIGNED_EN
            neg_res <= s1 ^ s2;
            neg_rem <= s1;
`endif
            state <= COMPUTING;
          end
        end
        COMPUTING: begin
          acc   <= acc_nxt;
          count <= count + 1'b1;
          if (count == LAST) begin
            state <= DONE;
            if (!is_div) begin
              {res2, res1} <= prod_fin;
            end else if (div_zero) begin
              // divide by zero returns the dividend as given, whatever the sign mode
              res1 <= '1;
              res2 <= op1_raw;
            end else begin
              res1 <= quot_fin;
              res2 <= rem_fin;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Result1 = res1;
  assign bus.Result2 = res2;
  assign bus.Busy    = ((state == IDLE) && bus.Start) || (state == COMPUTING);

endmodule
